// File: rtl/axi_slave_read_channel.sv
// AXI4 read slave: accepts one INCR burst at a time and streams it from a 1-cycle-latency SRAM via a 2-entry buffer.
// Optional macro AXI_SLAVE_RD_LATENCY_INJ_EN adds LFSR-driven random AR/issue stalls.
module axi_slave_read_channel #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int MEM_AW     = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [LEN_WIDTH-1:0]  ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic [1:0]            ARBURST,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic                  RLAST,
   output logic [1:0]            RRESP,
   output logic                  mem_ren,
   output logic [MEM_AW-1:0]     mem_raddr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic {IDLE, READ} state_t;

   localparam logic [LEN_WIDTH:0] LEN_ONE  = 1;
   localparam logic [MEM_AW-1:0]  ADDR_ONE = 1;

   state_t                state;
   logic [MEM_AW-1:0]     word_addr;
   logic [LEN_WIDTH:0]    beats;
   logic [LEN_WIDTH:0]    issued;
   logic                  err;
   logic                  vld_p1;
   logic                  last_p1;
   logic [DATA_WIDTH-1:0] buf_data [2];
   logic [1:0]            buf_last;
   logic [1:0]            buf_err;
   logic                  rd_ptr;
   logic                  wr_ptr;
   logic [1:0]            count;
   logic                  stall;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic                  ar_hs;
   logic [2:0]            occ;
   logic                  unused_addr_bits;

   assign unused_addr_bits = ^{ARADDR[ADDR_WIDTH-1:MEM_AW+2], ARADDR[1:0]};

`ifdef AXI_SLAVE_RD_LATENCY_INJ_EN
   logic [7:0] lfsr;

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr <= 8'hA5;
      else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign stall = lfsr[0];
`else
   assign stall = 1'b0;
`endif

   assign RVALID  = rst_n && (count != 2'd0);
   assign pop     = RVALID && RREADY;
   assign push    = vld_p1;
   // Occupancy the buffer will hold after this cycle if nothing new is issued.
   assign occ     = {1'b0, count} + {2'b00, vld_p1} - {2'b00, pop};
   assign issue   = rst_n && (state == READ) && (issued < beats) && (occ < 3'd2) && !stall;
   assign ARREADY = rst_n && (state == IDLE) && !stall;
   assign ar_hs   = ARVALID && ARREADY;

   assign mem_ren   = issue;
   assign mem_raddr = issue ? word_addr : '0;
   assign RDATA     = RVALID ? buf_data[rd_ptr] : '0;
   assign RLAST     = RVALID && buf_last[rd_ptr];
   assign RRESP     = (RVALID && buf_err[rd_ptr]) ? 2'b10 : 2'b00;
   assign busy      = rst_n && (state == READ);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         issued <= '0;
         vld_p1 <= 1'b0;
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         vld_p1 <= issue;
         if (issue) issued <= issued + LEN_ONE;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
         case (state)
            IDLE: if (ar_hs) begin
               state  <= READ;
               issued <= '0;
            end
            READ: if (pop && RLAST) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Burst parameters, SRAM-issue stage (p1) and buffer payload
   always_ff @(posedge clk) begin
      if (ar_hs) begin
         word_addr <= ARADDR[MEM_AW+1:2];
         beats     <= {1'b0, ARLEN} + LEN_ONE;
         err       <= (ARSIZE != 3'b010) || (ARBURST != 2'b01);
      end else if (issue) begin
         word_addr <= word_addr + ADDR_ONE;
      end
      if (issue) last_p1 <= (issued == beats - LEN_ONE);
      if (push) begin
         buf_data[wr_ptr] <= err ? '0 : mem_rdata;
         buf_last[wr_ptr] <= last_p1;
         buf_err[wr_ptr]  <= err;
      end
   end

endmodule

// File: tb/tb_axi_slave_read_channel.sv
// Directed bench for axi_slave_read_channel with a behavioural 1-cycle SRAM (sram[n] = n+100).
module tb_axi_slave_read_channel;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic        RVALID;
   logic        RREADY;
   logic [31:0] RDATA;
   logic        RLAST;
   logic [1:0]  RRESP;
   logic        mem_ren;
   logic [9:0]  mem_raddr;
   logic [31:0] mem_rdata;
   logic        busy;

   logic [31:0] sram [1024];
   int checks = 0;
   int errors = 0;
   int cyc = 0;

   axi_slave_read_channel dut (
      .clk(clk), .rst_n(rst_n),
      .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
      .ARSIZE(ARSIZE), .ARBURST(ARBURST),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RRESP(RRESP),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_ren) mem_rdata <= sram[mem_raddr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // mode 0: RREADY=1, mode 1: pattern 1,0,0 repeating, mode 2: random
   task automatic burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] bst,
                        input int mode, input bit tchk);
      int t0, tlast, first_ren, first_rv, beat, issues, pops, maxocc, stab_bad, wait_n, word;
      bit done, prev_stall, e;
      logic [31:0] pd;
      logic pl;
      logic [1:0] pr;
      first_ren = -1; first_rv = -1; tlast = -1; beat = 0; issues = 0; pops = 0;
      maxocc = 0; stab_bad = 0; done = 0; prev_stall = 0; pd = '0; pl = 0; pr = '0;
      e = (bst != 2'b01);
      @(negedge clk);
      ARVALID = 1; ARADDR = addr; ARLEN = len; ARSIZE = 3'b010; ARBURST = bst; RREADY = 0;
      #1;
      wait_n = 0;
      while (!ARREADY && wait_n < 100) begin
         @(negedge clk); #1; wait_n++;
      end
      chk("ar_accept", ARREADY, 1);
      t0 = cyc;
      for (int k = 0; k < 3000 && !done; k++) begin
         @(negedge clk);
         ARVALID = 0;
         case (mode)
            0:       RREADY = 1;
            1:       RREADY = ((k % 3) == 0);
            default: RREADY = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (k == 0) chk("busy", busy, 1);
         if (mem_ren) begin
            issues++;
            if (first_ren < 0) first_ren = cyc;
         end
         if (prev_stall && (!RVALID || RDATA !== pd || RLAST !== pl || RRESP !== pr)) stab_bad++;
         if (RVALID && first_rv < 0) first_rv = cyc;
         if (RVALID && RREADY) begin
            word = int'(((addr >> 2) + beat) % 1024);
            chk("rdata", RDATA, e ? 32'd0 : sram[word]);
            chk("rlast", RLAST, beat == int'(len));
            chk("rresp", RRESP, e ? 32'd2 : 32'd0);
            beat++;
            pops++;
            if (RLAST) begin
               done = 1;
               tlast = cyc;
            end
         end
         if (issues - pops > maxocc) maxocc = issues - pops;
         prev_stall = RVALID && !RREADY;
         pd = RDATA; pl = RLAST; pr = RRESP;
      end
      chk("burst_done", done, 1);
      chk("beat_count", beat, int'(len) + 1);
      chk("occupancy_le2", maxocc <= 2, 1);
      chk("stall_stable", stab_bad, 0);
      if (tchk) begin
`ifndef AXI_SLAVE_RD_LATENCY_INJ_EN
         chk("t_first_ren", first_ren - t0, 1);
         chk("t_first_rvalid", first_rv - t0, 3);
         chk("t_last_hs", tlast - t0, int'(len) + 3);
`endif
      end
      @(negedge clk);
      RREADY = 0;
      #1;
      chk("busy_after", busy, 0);
`ifndef AXI_SLAVE_RD_LATENCY_INJ_EN
      chk("arready_after", ARREADY, 1);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int hs, k;
      for (int i = 0; i < 1024; i++) sram[i] = 32'(i + 100);
      rst_n = 0; ARVALID = 0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'b010; ARBURST = 2'b01;
      RREADY = 0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_arready", ARREADY, 0);
      chk("rst_rvalid", RVALID, 0);
      chk("rst_rdata", RDATA, 0);
      chk("rst_rlast", RLAST, 0);
      chk("rst_rresp", RRESP, 0);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_mem_raddr", mem_raddr, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1;
      @(negedge clk);
      #1;
`ifndef AXI_SLAVE_RD_LATENCY_INJ_EN
      chk("arready_post_rst", ARREADY, 1);
`endif
      chk("rvalid_post_rst", RVALID, 0);

      burst(32'h40, 8'd7, 2'b01, 0, 1);
      burst(32'h40, 8'd7, 2'b01, 1, 0);
      burst(32'h80, 8'd0, 2'b01, 0, 1);
      burst(32'hFF8, 8'd255, 2'b01, 0, 1);
      burst(32'h40, 8'd3, 2'b00, 0, 1);
      burst(32'h44, 8'd3, 2'b01, 0, 1);

      // Reset in the middle of an 8-beat burst
      @(negedge clk);
      ARVALID = 1; ARADDR = 32'h40; ARLEN = 8'd7; ARBURST = 2'b01; RREADY = 1;
      #1;
      k = 0;
      while (!ARREADY && k < 100) begin
         @(negedge clk); #1; k++;
      end
      chk("mid_ar_accept", ARREADY, 1);
      hs = 0;
      for (int j = 0; j < 100 && hs < 3; j++) begin
         @(negedge clk);
         ARVALID = 0;
         #1;
         if (RVALID && RREADY) begin
            chk("mid_rdata", RDATA, sram[16 + hs]);
            hs++;
         end
      end
      chk("mid_reached_beat3", hs, 3);
      rst_n = 0;
      @(negedge clk);
      #1;
      chk("mid_rst_rvalid", RVALID, 0);
      chk("mid_rst_arready", ARREADY, 0);
      chk("mid_rst_mem_ren", mem_ren, 0);
      rst_n = 1;
      @(negedge clk);
      #1;
      chk("mid_post_rvalid", RVALID, 0);
      chk("mid_post_busy", busy, 0);
`ifndef AXI_SLAVE_RD_LATENCY_INJ_EN
      chk("mid_post_arready", ARREADY, 1);
`endif
      burst(32'h100, 8'd3, 2'b01, 0, 1);

      for (int r = 0; r < 20; r++) begin
         burst($urandom, 8'($urandom_range(0, 15)),
               ($urandom_range(0, 4) == 0) ? 2'b00 : 2'b01, 2, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
